// File: rtl/mem_block_writer_pkg.sv
// mem_if_pkg: constants and types shared by the block writer, the
// max-finder datapath and the 256x16 memory wrapper.
//   DATA_W  memory word width
//   ADDR_W  memory address width (depth = 2**ADDR_W)
//   CNT_W   block-length width (max block = 2**CNT_W-1 words)
//   wr_state_e  writer FSM state encoding
//   csum_add    modulo-2**DATA_W running-sum step
package mem_if_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // Sum wraps naturally at DATA_W bits.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/mem_block_writer_if.sv
// mem_block_writer_if: valid/ready word stream feeding the block writer.
//   in_data   stream word        (source -> writer)
//   in_valid  in_data is valid   (source -> writer)
//   in_ready  writer accepts     (writer -> source)
// modport master = stream source, modport slave = block writer.
interface mem_block_writer_if;
  import mem_if_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/mem_block_writer_addr_counter.sv
// wr_addr_counter: loadable modulo-2**ADDR_W address up-counter paired with
// a remaining-words down-counter.
//   clk_i, reset_i   clock and synchronous active-high reset
//   load_i           capture start_addr_i / n_i
//   start_addr_i     first address of the block
//   n_i              number of words in the block
//   step_i           one word accepted: advance address, decrement remaining
//   cur_addr_o       address for the next accepted word
//   last_o           the next accepted word is the final one (remaining==1)
module wr_addr_counter
  import mem_if_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CNT_W-1:0]  n_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;

  // Next-state: load wins over step; address wraps modulo 2**ADDR_W.
  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (load_i) begin
      cur_addr_d  = start_addr_i;
      remaining_d = n_i;
    end else if (step_i) begin
      cur_addr_d  = cur_addr_q + ADDR_W'(1);
      remaining_d = remaining_q - CNT_W'(1);
    end else begin
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_addr_q  <= ADDR_W'(0);
      remaining_q <= CNT_W'(0);
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign cur_addr_o = cur_addr_q;
  assign last_o     = (remaining_q == CNT_W'(1));

endmodule

// File: rtl/mem_block_writer.sv
// mem_block_writer: accepts N words over a valid/ready stream and writes them
// to consecutive memory addresses starting at startAddr (wrapping modulo
// 2**ADDR_W), then raises ActiveDone until ActiveWriter drops.
//   clk, reset     clock, synchronous active-high reset
//   ActiveWriter   level start; only looked at in IDLE
//   startAddr, N   block base address and length, captured at start
//   s              stream slave port (in_data / in_valid / in_ready)
//   wea/addr/dina  registered memory write port
//   ActiveDone     block complete, held until ActiveWriter=0
//   busy           high in every state except IDLE
// Optional build macro CHECKSUM_EN adds output `checksum`, the modulo-2**DATA_W
// sum of the words written in the current block.
module mem_block_writer
  import mem_if_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ActiveWriter,
  input  logic [ADDR_W-1:0]  startAddr,
  input  logic [CNT_W-1:0]   N,
  mem_block_writer_if.slave  s,
  output logic               wea,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  dina,
  output logic               ActiveDone,
`ifdef CHECKSUM_EN
  output logic [DATA_W-1:0]  checksum,
`endif
  output logic               busy
);

  wr_state_e         state_q;
  logic              wea_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dina_q;
  logic              done_q;
  logic              busy_q;

  logic              start_s;
  logic              accept_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic              last_s;

  // in_ready is decoded straight from the state so a word offered in WRITE
  // is taken in the same cycle.
  assign s.in_ready = (state_q == ST_WRITE);
  assign accept_s   = s.in_valid && s.in_ready;
  assign start_s    = (state_q == ST_IDLE) && ActiveWriter;

  wr_addr_counter u_cnt (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_i       (start_s),
    .start_addr_i (startAddr),
    .n_i          (N),
    .step_i       (accept_s),
    .cur_addr_o   (cur_addr_s),
    .last_o       (last_s)
  );

  // Writer FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wea_q   <= 1'b0;
      addr_q  <= ADDR_W'(0);
      dina_q  <= DATA_W'(0);
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wea_q <= 1'b0;
          if (ActiveWriter) begin
            busy_q <= 1'b1;
            if (N == CNT_W'(0)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (accept_s) begin
            wea_q  <= 1'b1;
            addr_q <= cur_addr_s;
            dina_q <= s.in_data;
            if (last_s) begin
              state_q <= ST_DRAIN;
            end
          end else begin
            wea_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Final write has been on the port for this cycle.
          wea_q   <= 1'b0;
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          wea_q <= 1'b0;
          if (!ActiveWriter) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wea_q   <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wea        = wea_q;
  assign addr       = addr_q;
  assign dina       = dina_q;
  assign ActiveDone = done_q;
  assign busy       = busy_q;

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Running block sum: cleared at start, stepped per accepted word.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= DATA_W'(0);
    end else if (start_s) begin
      checksum_q <= DATA_W'(0);
    end else if (accept_s) begin
      checksum_q <= csum_add(checksum_q, s.in_data);
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
